dispatch_router: RTL and testbench
==================================

# dispatch_router

Parametrised N-wide dispatch stage between rename and the three reservation stations (ALU, LSU, BRU). Each cycle it classifies up to DISPATCH_WIDTH renamed instructions by opcode and writes them into one small per-class FIFO. It then drains each FIFO in order, one entry per cycle, into its reservation station. Rename receives all-or-nothing backpressure, so a rename group is never split across cycles.

## Interface
- DISPATCH_WIDTH, 2, rename lanes per cycle (1..4)
- ROB_WIDTH, 4, ROB index width
- BUF_DEPTH, 4, entries per class FIFO; power of two, ≥ DISPATCH_WIDTH
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- flush  input  1  pipeline flush
- stall_dispatch  input  1  blocks acceptance of the current rename group
- rename_valid  input  DISPATCH_WIDTH  per-lane valid
- rename_instruction  input  DISPATCH_WIDTH × instruction_t  renamed instructions; lane 0 oldest
- rob_id  input  DISPATCH_WIDTH × ROB_WIDTH  per-lane ROB index
- dispatch_ready  output  1  group accepted this cycle when high
- alu_instruction, ls_instruction, branch_instruction  output  instruction_t  FIFO head per class
- alu_rob_id, ls_rob_id, branch_rob_id  output  ROB_WIDTH  ROB index of head
- alu_valid, ls_valid, branch_valid  output  1  head valid
- busy_alu, busy_lsu, busy_branch  input  1  RS cannot accept this cycle
- alu_count, ls_count, branch_count  output  $clog2(BUF_DEPTH+1)  FIFO occupancy

## Operation
- Classification per lane:
  - ALU = OP_IMM, OP, LUI, AUIPC, SYSTEM.
  - LS = LOAD, STORE.
  - BR = BRANCH, JAL, JALR.
  - Any other opcode goes to ALU, so the ROB entry still completes.
- need_c = number of valid lanes of class c.
- dispatch_ready = !flush && !stall_dispatch && for every class: count_c + need_c ≤ BUF_DEPTH.
  - Uses registered counts only. Same-cycle pops do not count toward space, so there is no path from busy_* to dispatch_ready.
- Accept = dispatch_ready && |rename_valid.
  - On accept, every valid lane is written to its class FIFO in lane order (lower lane at lower slot).
  - Up to DISPATCH_WIDTH writes into one FIFO per cycle.
- Pop_c = valid_c && !busy_c. Head advances one entry per cycle.
- Push and pop in the same cycle: count_c' = count_c + pushes − pop_c.
  - A full FIFO with a pop still rejects a group needing ≥1 slot.
- Pointers are log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. Count saturates neither way: overflow and underflow are impossible by construction, and the bench asserts this.
- Order is preserved within a class. No ordering guarantee across classes.
- Invalid lanes are ignored regardless of opcode. A group with all lanes invalid leaves state unchanged.

## Timing
- Reset (rst=0, asynchronous):
  - All pointers and counts go to 0.
  - alu_valid, ls_valid, branch_valid = 0.
  - *_count = 0.
  - Payload outputs are don't-care.
  - dispatch_ready = 1 combinationally once rst=1, provided flush and stall_dispatch are low.
- Latency: an instruction accepted at edge N appears on its class head outputs in cycle N+1 if that FIFO was empty. Minimum latency is 1 cycle; no bypass.
- *_valid = (count_c ≠ 0) && !flush. Payload and rob_id are read combinationally from the head slot.
- Flush:
  - While flush=1, all *_valid = 0, dispatch_ready = 0, and no pops occur.
  - At the edge with flush=1, all FIFOs are emptied (pointers and counts = 0).
  - Flush takes priority over a simultaneous accept or pop.
- stall_dispatch blocks pushes only. Pops continue.
- busy_* is sampled the same cycle as valid. The handshake completes at the rising edge.
- Reset asserted mid-operation discards all contents immediately. Nothing drains.

## Test plan
- Reset, then lanes {ADDI rob 1, LW rob 2} both valid, accepted at edge 0 → cycle 1: alu_valid=1 with rob 1, ls_valid=1 with rob 2, counts 1/1/0.
- Three groups of two ALU ops (rob 1..6), busy_alu=1, BUF_DEPTH=4 → first two groups accepted, dispatch_ready=0 on the third, alu_count=4. Release busy → pops in order rob 1,2,3,4; third group accepted once count ≤ 2.
- FIFO full (count 4), same cycle pop and a 1-ALU group → group rejected, count goes to 3. Next cycle accepted, count stays 3 (push+pop).
- Wrap: push and pop 10 BRU ops (JAL, rob 0..9) through a depth-4 FIFO with busy_branch toggling → output order exactly rob 0..9, branch_count never exceeds 4.
- Flush with two entries in each FIFO plus a valid rename group → *_valid=0 during flush, all counts 0 after the edge, group not enqueued.
- Unknown opcode (7'h7F) in lane 1 with a valid STORE in lane 0 → STORE goes to LSU, unknown goes to ALU. An invalid lane carrying LOAD does not change ls_count.

Source files
------------

// File: rtl/dispatch_router.sv
//------------------------------------------------------------------------------
// dispatch_router
//   N-wide dispatch stage between rename and the ALU / LSU / BRU reservation
//   stations. Each accepted rename group is split by opcode class into three
//   small in-order FIFOs; each FIFO drains one entry per cycle into its RS.
//   Rename sees all-or-nothing backpressure so a group is never split.
//
//   Ports
//     clk, rst (async, active-low), flush, stall_dispatch
//     rename_valid / rename_instruction / rob_id : per-lane rename group
//     dispatch_ready                              : group accepted when high
//     {alu,ls,branch}_{instruction,rob_id,valid}  : FIFO head per class
//     busy_{alu,lsu,branch}                       : RS cannot accept
//     {alu,ls,branch}_count                       : FIFO occupancy
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dispatch_router #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ROB_WIDTH      = 4,
  parameter int BUF_DEPTH      = 4,   // power of two, >= 2 and >= DISPATCH_WIDTH
  parameter int INSTR_WIDTH    = 32,  // opcode lives in bits [6:0]
  // derived
  parameter int CNT_W          = $clog2(BUF_DEPTH + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic                                        stall_dispatch,
  input  logic [DISPATCH_WIDTH-1:0]                   rename_valid,
  input  logic [DISPATCH_WIDTH-1:0][INSTR_WIDTH-1:0]  rename_instruction,
  input  logic [DISPATCH_WIDTH-1:0][ROB_WIDTH-1:0]    rob_id,
  output logic                                        dispatch_ready,
  output logic [INSTR_WIDTH-1:0]                      alu_instruction,
  output logic [INSTR_WIDTH-1:0]                      ls_instruction,
  output logic [INSTR_WIDTH-1:0]                      branch_instruction,
  output logic [ROB_WIDTH-1:0]                        alu_rob_id,
  output logic [ROB_WIDTH-1:0]                        ls_rob_id,
  output logic [ROB_WIDTH-1:0]                        branch_rob_id,
  output logic                                        alu_valid,
  output logic                                        ls_valid,
  output logic                                        branch_valid,
  input  logic                                        busy_alu,
  input  logic                                        busy_lsu,
  input  logic                                        busy_branch,
  output logic [CNT_W-1:0]                            alu_count,
  output logic [CNT_W-1:0]                            ls_count,
  output logic [CNT_W-1:0]                            branch_count
);

  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int NUM_CLASS = 3;

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_LS  = 2'd1;
  localparam logic [1:0] CLS_BR  = 2'd2;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

  // OP_IMM, OP, LUI, AUIPC, SYSTEM and every unrecognised opcode land in the
  // ALU class, so the ROB entry of an illegal/unknown op still completes.
  function automatic logic [1:0] classify(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE:            classify = CLS_LS;
      OPC_BRANCH, OPC_JAL, OPC_JALR:  classify = CLS_BR;
      default:                        classify = CLS_ALU;
    endcase
  endfunction

  logic [1:0]             lane_cls [DISPATCH_WIDTH];
  logic [PTR_W-1:0]       lane_off [DISPATCH_WIDTH];
  logic [CNT_W-1:0]       need     [NUM_CLASS];
  logic [CNT_W-1:0]       count_q  [NUM_CLASS];
  logic [INSTR_WIDTH-1:0] head_instr [NUM_CLASS];
  logic [ROB_WIDTH-1:0]   head_rob   [NUM_CLASS];
  logic [NUM_CLASS-1:0]   head_valid;
  logic [NUM_CLASS-1:0]   busy_vec;
  logic                   space_ok;
  logic                   accept;

  assign busy_vec = {busy_branch, busy_lsu, busy_alu};

  // Per-lane class, per-class demand, and each lane's slot offset from the
  // class write pointer (number of older valid lanes of the same class).
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      need[c] = '0;
    end
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      lane_cls[l] = classify(rename_instruction[l][6:0]);
      lane_off[l] = '0;
    end
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        if (rename_valid[l] && (lane_cls[l] == 2'(c))) begin
          lane_off[l] = PTR_W'(need[c]);
          need[c]     = need[c] + CNT_W'(1);
        end
      end
    end
  end

  // Space check uses registered counts only; a same-cycle pop never frees a
  // slot for this group, which keeps busy_* off the dispatch_ready path.
  always_comb begin
    space_ok = 1'b1;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (({1'b0, count_q[c]} + {1'b0, need[c]}) > DEPTH_LIM) begin
        space_ok = 1'b0;
      end
    end
  end

  assign dispatch_ready = !flush && !stall_dispatch && space_ok;
  assign accept         = dispatch_ready && (|rename_valid);

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_class
    logic [INSTR_WIDTH-1:0] mem_instr [BUF_DEPTH];
    logic [ROB_WIDTH-1:0]   mem_rob   [BUF_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       push_n;
    logic                   pop;

    assign head_valid[c] = (cnt != '0) && !flush;
    assign pop           = head_valid[c] && !busy_vec[c];
    assign push_n        = accept ? need[c] : '0;
    assign head_instr[c] = mem_instr[rd_ptr];
    assign head_rob[c]   = mem_rob[rd_ptr];
    assign count_q[c]    = cnt;

    // accept and pop are both forced low by flush, so the flush branch
    // only needs to clear state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(push_n);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        cnt    <= cnt + push_n - CNT_W'(pop);
      end
    end

    // Payload storage is not reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
      if (accept) begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
          if (rename_valid[l] && (lane_cls[l] == 2'(c))) begin
            mem_instr[wr_ptr + lane_off[l]] <= rename_instruction[l];
            mem_rob[wr_ptr + lane_off[l]]   <= rob_id[l];
          end
        end
      end
    end
  end

  assign alu_valid          = head_valid[CLS_ALU];
  assign ls_valid           = head_valid[CLS_LS];
  assign branch_valid       = head_valid[CLS_BR];
  assign alu_instruction    = head_instr[CLS_ALU];
  assign ls_instruction     = head_instr[CLS_LS];
  assign branch_instruction = head_instr[CLS_BR];
  assign alu_rob_id         = head_rob[CLS_ALU];
  assign ls_rob_id          = head_rob[CLS_LS];
  assign branch_rob_id      = head_rob[CLS_BR];
  assign alu_count          = count_q[CLS_ALU];
  assign ls_count           = count_q[CLS_LS];
  assign branch_count       = count_q[CLS_BR];

endmodule

`default_nettype wire

// File: tb/tb_dispatch_router.sv
//------------------------------------------------------------------------------
// tb_dispatch_router
//   Table-driven bench for dispatch_router with a per-class scoreboard.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dispatch_router;

  localparam int W  = 2;
  localparam int RW = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush, stall_dispatch;
  logic [W-1:0]      rename_valid;
  logic [W-1:0][31:0] rename_instruction;
  logic [W-1:0][RW-1:0] rob_id;
  logic              dispatch_ready;
  logic [31:0]       alu_instruction, ls_instruction, branch_instruction;
  logic [RW-1:0]     alu_rob_id, ls_rob_id, branch_rob_id;
  logic              alu_valid, ls_valid, branch_valid;
  logic              busy_alu, busy_lsu, busy_branch;
  logic [CW-1:0]     alu_count, ls_count, branch_count;

  always #5 clk = ~clk;

  dispatch_router #(.DISPATCH_WIDTH(W), .ROB_WIDTH(RW), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_dispatch(stall_dispatch),
    .rename_valid(rename_valid), .rename_instruction(rename_instruction),
    .rob_id(rob_id), .dispatch_ready(dispatch_ready),
    .alu_instruction(alu_instruction), .ls_instruction(ls_instruction),
    .branch_instruction(branch_instruction),
    .alu_rob_id(alu_rob_id), .ls_rob_id(ls_rob_id), .branch_rob_id(branch_rob_id),
    .alu_valid(alu_valid), .ls_valid(ls_valid), .branch_valid(branch_valid),
    .busy_alu(busy_alu), .busy_lsu(busy_lsu), .busy_branch(busy_branch),
    .alu_count(alu_count), .ls_count(ls_count), .branch_count(branch_count)
  );

  typedef struct packed {
    logic [31:0]   ins;
    logic [RW-1:0] rob;
  } ent_t;

  typedef struct {
    logic       fl;
    logic       st;
    logic [1:0] v;
    logic [6:0] o0;
    logic [3:0] r0;
    logic [6:0] o1;
    logic [3:0] r1;
    logic [2:0] bz;   // {branch, lsu, alu}
    int         er;   // expected dispatch_ready, -1 = model only
  } vec_t;

  ent_t q_alu[$];
  ent_t q_ls[$];
  ent_t q_br[$];
  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] ADDI = 7'h13, OPR = 7'h33, LW = 7'h03, SW = 7'h23;
  localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, BEQ = 7'h63, UNK = 7'h7F;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] r);
    return {r, 21'h0ABCD, op};
  endfunction

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'h03, 7'h23:        return 1;
      7'h63, 7'h6F, 7'h67: return 2;
      default:             return 0;
    endcase
  endfunction

  function automatic vec_t V(input logic fl, input logic st, input logic [1:0] v,
                             input logic [6:0] o0, input logic [3:0] r0,
                             input logic [6:0] o1, input logic [3:0] r1,
                             input logic [2:0] bz, input int er);
    vec_t t;
    t.fl = fl; t.st = st; t.v = v; t.o0 = o0; t.r0 = r0; t.o1 = o1; t.r1 = r1;
    t.bz = bz; t.er = er;
    return t;
  endfunction

  function automatic int qsize(input int c);
    case (c)
      0:       return q_alu.size();
      1:       return q_ls.size();
      default: return q_br.size();
    endcase
  endfunction

  function automatic ent_t qfront(input int c);
    case (c)
      0:       return q_alu[0];
      1:       return q_ls[0];
      default: return q_br[0];
    endcase
  endfunction

  task automatic qpop(input int c);
    case (c)
      0:       void'(q_alu.pop_front());
      1:       void'(q_ls.pop_front());
      default: void'(q_br.pop_front());
    endcase
  endtask

  task automatic qpush(input int c, input ent_t e);
    case (c)
      0:       q_alu.push_back(e);
      1:       q_ls.push_back(e);
      default: q_br.push_back(e);
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_counts();
    chk("alu_count", 64'(alu_count), 64'(q_alu.size()));
    chk("ls_count", 64'(ls_count), 64'(q_ls.size()));
    chk("branch_count", 64'(branch_count), 64'(q_br.size()));
    chk("count_bound", 64'((alu_count <= D) && (ls_count <= D) && (branch_count <= D)), 64'(1));
  endtask

  // One cycle: drive at posedge+1, check comb outputs mid-cycle, update the
  // model with the handshakes of this cycle, then check counts after the edge.
  task automatic step(input vec_t t, output logic acc);
    int          need [3];
    int          lc [2];
    logic        exp_rdy;
    logic        ev;
    logic [2:0]  dv;
    logic [31:0] di [3];
    logic [3:0]  dr [3];
    ent_t        f;
    flush = t.fl; stall_dispatch = t.st; rename_valid = t.v;
    rename_instruction[0] = mk(t.o0, t.r0); rob_id[0] = t.r0;
    rename_instruction[1] = mk(t.o1, t.r1); rob_id[1] = t.r1;
    busy_alu = t.bz[0]; busy_lsu = t.bz[1]; busy_branch = t.bz[2];
    #2;
    lc[0] = cls_of(t.o0); lc[1] = cls_of(t.o1);
    for (int c = 0; c < 3; c++) need[c] = 0;
    for (int l = 0; l < 2; l++) if (t.v[l]) need[lc[l]]++;
    exp_rdy = !t.fl && !t.st;
    for (int c = 0; c < 3; c++) if (qsize(c) + need[c] > D) exp_rdy = 1'b0;
    chk("dispatch_ready_model", 64'(dispatch_ready), 64'(exp_rdy));
    if (t.er >= 0) chk("dispatch_ready_table", 64'(dispatch_ready), 64'(t.er));
    dv = {branch_valid, ls_valid, alu_valid};
    di[0] = alu_instruction; di[1] = ls_instruction; di[2] = branch_instruction;
    dr[0] = alu_rob_id; dr[1] = ls_rob_id; dr[2] = branch_rob_id;
    for (int c = 0; c < 3; c++) begin
      ev = (qsize(c) != 0) && !t.fl;
      chk($sformatf("valid[%0d]", c), 64'(dv[c]), 64'(ev));
      if (ev) begin
        f = qfront(c);
        chk($sformatf("head_rob[%0d]", c), 64'(dr[c]), 64'(f.rob));
        chk($sformatf("head_instr[%0d]", c), 64'(di[c]), 64'(f.ins));
      end
    end
    acc = exp_rdy && (|t.v);
    if (t.fl) begin
      q_alu.delete(); q_ls.delete(); q_br.delete();
    end else begin
      for (int c = 0; c < 3; c++)
        if ((qsize(c) != 0) && !t.bz[c]) qpop(c);
      if (acc) begin
        if (t.v[0]) qpush(lc[0], '{ins: mk(t.o0, t.r0), rob: t.r0});
        if (t.v[1]) qpush(lc[1], '{ins: mk(t.o1, t.r1), rob: t.r1});
      end
    end
    @(posedge clk); #1;
    chk_counts();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   sent;
    int   cyc;

    rst = 1'b0; flush = 1'b0; stall_dispatch = 1'b0; rename_valid = '0;
    rename_instruction = '0; rob_id = '0;
    busy_alu = 1'b0; busy_lsu = 1'b0; busy_branch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_valid", 64'(alu_valid), 64'(0));
    chk("rst_ls_valid", 64'(ls_valid), 64'(0));
    chk("rst_branch_valid", 64'(branch_valid), 64'(0));
    chk_counts();
    rst = 1'b1;
    #1;
    chk("rst_release_ready", 64'(dispatch_ready), 64'(1));

    // basic split
    tbl.push_back(V(0,0,2'b11, ADDI,1, LW,2,   3'b111, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    // fill ALU with busy, third group blocked until count <= 2
    tbl.push_back(V(0,0,2'b11, ADDI,1, OPR,2,  3'b001, 1));
    tbl.push_back(V(0,0,2'b11, ADDI,3, ADDI,4, 3'b001, 1));
    tbl.push_back(V(0,0,2'b11, ADDI,5, ADDI,6, 3'b001, 0));
    tbl.push_back(V(0,0,2'b11, ADDI,5, ADDI,6, 3'b000, 0));
    tbl.push_back(V(0,0,2'b11, ADDI,5, ADDI,6, 3'b000, 0));
    tbl.push_back(V(0,0,2'b11, ADDI,5, ADDI,6, 3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    // full FIFO + pop + 1-ALU group: rejected, then accepted with push+pop
    tbl.push_back(V(0,0,2'b11, ADDI,7, ADDI,8,  3'b001, 1));
    tbl.push_back(V(0,0,2'b11, ADDI,9, ADDI,10, 3'b001, 1));
    tbl.push_back(V(0,0,2'b01, ADDI,11, ADDI,0, 3'b000, 0));
    tbl.push_back(V(0,0,2'b01, ADDI,11, ADDI,0, 3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    // two entries per class, then flush with a valid group
    tbl.push_back(V(0,0,2'b11, ADDI,1, LW,2,   3'b111, 1));
    tbl.push_back(V(0,0,2'b11, JAL,3,  SW,4,   3'b111, 1));
    tbl.push_back(V(0,0,2'b11, OPR,5,  JALR,6, 3'b111, 1));
    tbl.push_back(V(1,0,2'b11, ADDI,7, LW,8,   3'b000, 0));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    // unknown opcode to ALU; invalid LOAD lane ignored
    tbl.push_back(V(0,0,2'b11, SW,1,   UNK,2,  3'b111, 1));
    tbl.push_back(V(0,0,2'b01, ADDI,3, LW,4,   3'b111, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    // stall blocks pushes; branch pair
    tbl.push_back(V(0,1,2'b11, ADDI,1, JAL,2,  3'b000, 0));
    tbl.push_back(V(0,0,2'b11, JAL,1,  BEQ,2,  3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));
    tbl.push_back(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1));

    foreach (tbl[i]) step(tbl[i], acc);

    // wrap: 10 JALs through the depth-4 branch FIFO with busy toggling
    sent = 0;
    cyc  = 0;
    while (((sent < 10) || (q_br.size() != 0)) && (cyc < 200)) begin
      step(V(0, 0, (sent < 10) ? 2'b11 : 2'b00, JAL, 4'(sent), JAL, 4'(sent + 1),
             {cyc[0] | cyc[1], 2'b00}, -1), acc);
      if (acc) sent += 2;
      cyc++;
    end
    chk("wrap_complete", 64'((sent == 10) && (q_br.size() == 0)), 64'(1));

    // asynchronous reset mid-operation discards everything
    step(V(0,0,2'b11, ADDI,1, LW,2,  3'b111, 1), acc);
    step(V(0,0,2'b11, JAL,3,  ADDI,4, 3'b111, 1), acc);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_alu_valid", 64'(alu_valid), 64'(0));
    chk("async_rst_ls_valid", 64'(ls_valid), 64'(0));
    chk("async_rst_branch_valid", 64'(branch_valid), 64'(0));
    q_alu.delete(); q_ls.delete(); q_br.delete();
    chk_counts();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(dispatch_ready), 64'(1));
    step(V(0,0,2'b00, ADDI,0, ADDI,0, 3'b000, 1), acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
